// File: rtl/usr_pkg.sv
// Shared types and helpers for the parametrised universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    SHR   = 3'b001,
    SHL   = 3'b010,
    LOAD  = 3'b011,
    CLR_Q = 3'b100,
    ROR   = 3'b101,
    ROL   = 3'b110,
    ASR   = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Modes that a burst may repeat; everything else is a one-shot op.
  function automatic logic is_shift(input mode_t m);
    return (m == SHR) || (m == SHL) || (m == ROR) || (m == ROL) || (m == ASR);
  endfunction

endpackage

// File: rtl/usr_step_logic.sv
// One step of the register datapath: next Q and serial-out bits for a mode.
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_t              mode_i,
  input  logic [WIDTH-1:0]   q_i,
  input  logic [WIDTH-1:0]   d_i,
  input  logic               lsd_i,
  input  logic               rsd_i,
  input  logic               sor_i,
  input  logic               sol_i,
  output logic [WIDTH-1:0]   q_o,
  output logic               sor_o,
  output logic               sol_o
);

  always_comb begin
    q_o   = q_i;
    sor_o = sor_i;
    sol_o = sol_i;
    case (mode_i)
      HOLD:  q_o = q_i;
      SHR: begin
        q_o   = {lsd_i, q_i[WIDTH-1:1]};
        sor_o = q_i[0];
      end
      SHL: begin
        q_o   = {q_i[WIDTH-2:0], rsd_i};
        sol_o = q_i[WIDTH-1];
      end
      LOAD:  q_o = d_i;
      CLR_Q: q_o = '0;
      ROR: begin
        q_o   = {q_i[0], q_i[WIDTH-1:1]};
        sor_o = q_i[0];
      end
      ROL: begin
        q_o   = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        sol_o = q_i[WIDTH-1];
      end
      ASR: begin
        q_o   = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        sor_o = q_i[0];
      end
      default: q_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_p.sv
// Parametrised universal shift register with an autonomous N-step burst engine.
module univ_shift_reg_p
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             LSD,
  input  logic             RSD,
  input  logic             START,
  input  logic [CW-1:0]    CNT,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_t           state_q;
  mode_t            mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             sor_q;
  logic             sol_q;
  logic             busy_q;
  logic             done_q;

  mode_t            mode_in;
  mode_t            step_mode;
  logic [CW-1:0]    cnt_sat;
  logic [WIDTH-1:0] q_d;
  logic             sor_d;
  logic             sol_d;

  assign mode_in   = mode_t'(MODE);
  assign cnt_sat   = (CNT > CNT_MAX) ? CNT_MAX : CNT;
  // While a burst runs the latched mode drives the datapath, not the live MODE.
  assign step_mode = (state_q == ST_RUN) ? mode_q : mode_in;

  usr_step_logic #(.WIDTH(WIDTH)) u_step (
    .mode_i (step_mode),
    .q_i    (q_q),
    .d_i    (D),
    .lsd_i  (LSD),
    .rsd_i  (RSD),
    .sor_i  (sor_q),
    .sol_i  (sol_q),
    .q_o    (q_d),
    .sor_o  (sor_d),
    .sol_o  (sol_d)
  );

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      mode_q  <= HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      sor_q   <= 1'b0;
      sol_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (EN) begin
      case (state_q)
        ST_IDLE: begin
          if (!START) begin
            q_q   <= q_d;
            sor_q <= sor_d;
            sol_q <= sol_d;
          end else if (is_shift(mode_in) && (cnt_sat != '0)) begin
            q_q    <= q_d;
            sor_q  <= sor_d;
            sol_q  <= sol_d;
            mode_q <= mode_in;
            cnt_q  <= cnt_sat - CW'(1);
            if (cnt_sat > CW'(1)) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end
          end else begin
            // Zero-length shift burst leaves Q alone; other ops run once.
            if (!is_shift(mode_in)) begin
              q_q   <= q_d;
              sor_q <= sor_d;
              sol_q <= sol_d;
            end
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          q_q   <= q_d;
          sor_q <= sor_d;
          sol_q <= sol_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign SOR  = sor_q;
  assign SOL  = sol_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Directed bench for univ_shift_reg_p: legacy ops, extended modes, bursts, EN/CLR.
module tb_univ_shift_reg_p;

  logic       clk = 1'b0;
  logic       CLR, EN;
  logic [2:0] MODE;
  logic [7:0] D;
  logic       LSD, RSD, START;
  logic [3:0] CNT;
  logic [7:0] Q;
  logic       SOR, SOL, BUSY, DONE;

  logic [2:0]  mode16;
  logic [15:0] d16;
  logic        lsd16, rsd16, start16;
  logic [4:0]  cnt16;
  logic [15:0] q16;
  logic        sor16, sol16, busy16, done16;

  int total = 0;
  int bad   = 0;
  int n;
  int dones;

  always #5 clk = ~clk;

  univ_shift_reg_p #(.WIDTH(8)) dut (
    .clk(clk), .CLR(CLR), .EN(EN), .MODE(MODE), .D(D), .LSD(LSD), .RSD(RSD),
    .START(START), .CNT(CNT), .Q(Q), .SOR(SOR), .SOL(SOL), .BUSY(BUSY), .DONE(DONE)
  );

  univ_shift_reg_p #(.WIDTH(16)) dut16 (
    .clk(clk), .CLR(CLR), .EN(EN), .MODE(mode16), .D(d16), .LSD(lsd16), .RSD(rsd16),
    .START(start16), .CNT(cnt16), .Q(q16), .SOR(sor16), .SOL(sol16), .BUSY(busy16),
    .DONE(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] v);
    MODE = 3'b011; D = v; START = 1'b0;
    tick();
    MODE = 3'b000;
  endtask

  initial begin
    CLR = 1'b1; EN = 1'b1; MODE = 3'b000; D = 8'h00; LSD = 1'b0; RSD = 1'b0;
    START = 1'b0; CNT = 4'd0;
    mode16 = 3'b000; d16 = 16'h0; lsd16 = 1'b0; rsd16 = 1'b0; start16 = 1'b0; cnt16 = 5'd0;
    #2;
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_sor_sol", 32'({SOR, SOL}), 32'h0);
    chk("rst_busy_done", 32'({BUSY, DONE}), 32'h0);
    tick();
    CLR = 1'b0;

    // Legacy ops
    MODE = 3'b011; D = 8'hAA; tick();
    chk("load_aa", 32'(Q), 32'hAA);
    MODE = 3'b001; LSD = 1'b1; tick();
    chk("shr_q", 32'(Q), 32'hD5);
    chk("shr_sor", 32'(SOR), 32'h0);
    MODE = 3'b010; RSD = 1'b0; tick();
    chk("shl_q", 32'(Q), 32'hAA);
    chk("shl_sol", 32'(SOL), 32'h1);
    MODE = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", 32'(Q), 32'hAA);
    end

    // Extended modes
    load8(8'h81);
    MODE = 3'b101; tick();
    chk("ror_q", 32'(Q), 32'hC0);
    chk("ror_sor", 32'(SOR), 32'h1);
    load8(8'h81);
    MODE = 3'b110; tick();
    chk("rol_q", 32'(Q), 32'h03);
    chk("rol_sol", 32'(SOL), 32'h1);
    load8(8'h80);
    MODE = 3'b111; tick();
    chk("asr_q", 32'(Q), 32'hC0);
    chk("asr_sor", 32'(SOR), 32'h0);
    MODE = 3'b100; tick();
    chk("sclr_q", 32'(Q), 32'h00);

    // Burst rotate left x3 from 01; MODE changes mid-burst must be ignored
    load8(8'h01);
    MODE = 3'b110; START = 1'b1; CNT = 4'd3; tick();
    chk("brst_s1_q", 32'(Q), 32'h02);
    chk("brst_s1_busy", 32'({BUSY, DONE}), 32'h2);
    START = 1'b0; MODE = 3'b011; D = 8'hFF; tick();
    chk("brst_s2_q", 32'(Q), 32'h04);
    chk("brst_s2_busy", 32'({BUSY, DONE}), 32'h2);
    tick();
    chk("brst_s3_q", 32'(Q), 32'h08);
    chk("brst_s3_done", 32'({BUSY, DONE}), 32'h1);
    tick();
    chk("brst_fin_q", 32'(Q), 32'h08);
    chk("brst_fin_done", 32'({BUSY, DONE}), 32'h0);
    MODE = 3'b000;

    // CNT=0 burst: Q unchanged, DONE pulse
    MODE = 3'b001; START = 1'b1; CNT = 4'd0; tick();
    chk("cnt0_q", 32'(Q), 32'h08);
    chk("cnt0_done", 32'({BUSY, DONE}), 32'h1);
    START = 1'b0; MODE = 3'b000; tick();
    chk("cnt0_done_off", 32'(DONE), 32'h0);

    // Full-width ROR from A5 with a START during BUSY that must be dropped
    load8(8'hA5);
    MODE = 3'b101; START = 1'b1; CNT = 4'd8; tick();
    chk("ror8_s1_q", 32'(Q), 32'hD2);
    chk("ror8_s1_busy", 32'(BUSY), 32'h1);
    for (int i = 2; i <= 8; i++) begin
      if (i == 4) begin
        START = 1'b1; MODE = 3'b011; D = 8'h00; CNT = 4'd1;
      end else begin
        START = 1'b0; MODE = 3'b000;
      end
      tick();
      if (i < 8) chk("ror8_busy", 32'({BUSY, DONE}), 32'h2);
    end
    chk("ror8_q", 32'(Q), 32'hA5);
    chk("ror8_done", 32'({BUSY, DONE}), 32'h1);
    tick();
    chk("ror8_idle", 32'({BUSY, DONE}), 32'h0);
    chk("ror8_q_after", 32'(Q), 32'hA5);

    // Out-of-range CNT saturates to WIDTH steps
    load8(8'h3C);
    MODE = 3'b110; START = 1'b1; CNT = 4'd15; tick();
    START = 1'b0; MODE = 3'b000;
    n = 0;
    while (!DONE && n < 20) begin
      tick();
      n++;
    end
    chk("sat_cycles", 32'(n), 32'd7);
    chk("sat_q", 32'(Q), 32'h3C);
    tick();

    // EN=0 freezes a running SHL burst
    MODE = 3'b100; tick();
    MODE = 3'b010; RSD = 1'b1; START = 1'b1; CNT = 4'd4; tick();
    chk("en_s1_q", 32'(Q), 32'h01);
    START = 1'b0; MODE = 3'b000; tick();
    chk("en_s2_q", 32'(Q), 32'h03);
    EN = 1'b0;
    tick();
    chk("en_frz1_q", 32'(Q), 32'h03);
    tick();
    chk("en_frz2_q", 32'(Q), 32'h03);
    chk("en_frz2_busy", 32'({BUSY, DONE}), 32'h2);
    EN = 1'b1;
    tick();
    chk("en_s3_q", 32'(Q), 32'h07);
    tick();
    chk("en_s4_q", 32'(Q), 32'h0F);
    chk("en_s4_done", 32'({BUSY, DONE}), 32'h1);
    tick();
    chk("en_fin", 32'(DONE), 32'h0);

    // Asynchronous CLR mid-burst
    MODE = 3'b001; LSD = 1'b0; START = 1'b1; CNT = 4'd5; tick();
    chk("clr_s1_q", 32'(Q), 32'h07);
    START = 1'b0; MODE = 3'b000; tick();
    chk("clr_s2_q", 32'(Q), 32'h03);
    #2 CLR = 1'b1;
    #1;
    chk("clr_async_q", 32'(Q), 32'h00);
    chk("clr_async_bd", 32'({BUSY, DONE}), 32'h0);
    tick();
    CLR = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DONE || BUSY) dones++;
    end
    chk("clr_no_done", 32'(dones), 32'd0);
    chk("clr_q_after", 32'(Q), 32'h00);

    // WIDTH=16: SHR x16 with LSD=1 fills the register with ones
    mode16 = 3'b001; lsd16 = 1'b1; start16 = 1'b1; cnt16 = 5'd16; tick();
    chk("w16_s1_q", 32'(q16), 32'h8000);
    chk("w16_s1_busy", 32'(busy16), 32'h1);
    start16 = 1'b0; mode16 = 3'b000;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done16) begin
        dones++;
        chk("w16_done_q", 32'(q16), 32'hFFFF);
      end
    end
    chk("w16_done_cnt", 32'(dones), 32'd1);
    chk("w16_q_final", 32'(q16), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
